contador_arbitro: RTL and testbench

CONTADOR_ARBITRO -- requirements
Module: contador_arbitro

---
 rtl/contador_pkg.sv | 15 +
 rtl/contador_passo.sv | 32 +++
 rtl/contador_arbitro.sv | 144 ++++++++++++++
 tb/tb_contador_arbitro.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/contador_pkg.sv
// Shared types and constants for the round-robin arbitrated step counter.
package contador_pkg;

  localparam int NBITS_CONTAGEM     = 4;
  localparam int ENTRADA            = 1;
  localparam int ENTRADA_DECREMENTO = 3;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CARREGA = 2'd1,
    CONTA   = 2'd2,
    FIM     = 2'd3
  } estado_t;

endpackage

// File: rtl/contador_passo.sv
// Combinational next-value for one counter step: direction, step size (1 or 3),
// and wrap or clamp at the range limits.
module contador_passo #(
  parameter int NBITS = contador_pkg::NBITS_CONTAGEM
) (
  input  logic [NBITS-1:0] i_valor,
  input  logic             i_decrescente,
  input  logic             i_passo3,
  input  logic             i_satura,
  output logic [NBITS-1:0] o_proximo
);
  import contador_pkg::*;

  logic [NBITS:0] w_passo;
  logic [NBITS:0] w_soma;
  logic [NBITS:0] w_dif;

  // one extra bit catches carry (up) or borrow (down) for the clamp decision
  assign w_passo = i_passo3 ? (NBITS+1)'(ENTRADA_DECREMENTO) : (NBITS+1)'(ENTRADA);
  assign w_soma  = {1'b0, i_valor} + w_passo;
  assign w_dif   = {1'b0, i_valor} - w_passo;

  always_comb begin
    o_proximo = '0;
    if (i_decrescente) begin
      o_proximo = (i_satura && w_dif[NBITS]) ? '0 : w_dif[NBITS-1:0];
    end else begin
      o_proximo = (i_satura && w_soma[NBITS]) ? '1 : w_soma[NBITS-1:0];
    end
  end

endmodule

// File: rtl/contador_arbitro.sv
// Two-requester round-robin arbiter owning a shared step counter; each granted
// run loads a start value and applies a programmed number of steps.
//
// state   | meaning
// OCIOSO  | idle, waiting for any req; grant and latch commands on exit
// CARREGA | load counter with start value and remaining-step count
// CONTA   | one step per non-frozen cycle until remaining reaches zero
// FIM     | done pulse on granted bit, release grant, record last served
module contador_arbitro #(
  parameter int NBITS_CONTAGEM = contador_pkg::NBITS_CONTAGEM,
  parameter int NBITS_PASSOS   = 4
) (
  input  logic                        clk_2,
  input  logic                        reset_n,
  input  logic [1:0]                  req,
  input  logic [1:0]                  cmd_decrescente,
  input  logic [1:0]                  cmd_passo3,
  input  logic [1:0]                  cmd_satura,
  input  logic [2*NBITS_CONTAGEM-1:0] cmd_inicio,
  input  logic [2*NBITS_PASSOS-1:0]   cmd_passos,
  input  logic                        congela,
  output logic [1:0]                  gnt,
  output logic [1:0]                  done,
  output logic                        ocupado,
  output logic [NBITS_CONTAGEM-1:0]   contagem,
  output logic [NBITS_CONTAGEM-1:0]   resultado
);
  import contador_pkg::*;

  localparam int NC = NBITS_CONTAGEM;
  localparam int NP = NBITS_PASSOS;

  estado_t         r_estado;
  estado_t         w_proximo_estado;
  logic [1:0]      r_gnt;
  logic            r_ultimo;
  logic            r_decrescente;
  logic            r_passo3;
  logic            r_satura;
  logic [NC-1:0]   r_inicio;
  logic [NP-1:0]   r_passos;
  logic [NP-1:0]   r_restante;
  logic [NC-1:0]   r_contagem;
  logic [NC-1:0]   r_resultado;
  logic [NC-1:0]   w_passo_valor;
  logic            w_idx;
  logic [1:0]      w_gnt_novo;

  // contention goes to whoever was not served last; a lone requester always wins
  always_comb begin
    w_idx = req[1];
    if (req == 2'b11) begin
      w_idx = ~r_ultimo;
    end
  end

  assign w_gnt_novo = w_idx ? 2'b10 : 2'b01;

  contador_passo #(
    .NBITS(NC)
  ) u_passo (
    .i_valor       (r_contagem),
    .i_decrescente (r_decrescente),
    .i_passo3      (r_passo3),
    .i_satura      (r_satura),
    .o_proximo     (w_passo_valor)
  );

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_proximo_estado;
    end
  end

  always_comb begin
    w_proximo_estado = r_estado;
    case (r_estado)
      OCIOSO:  if (|req) w_proximo_estado = CARREGA;
      CARREGA: w_proximo_estado = (r_passos == '0) ? FIM : CONTA;
      CONTA:   if (!congela && r_restante == NP'(1)) w_proximo_estado = FIM;
      FIM:     w_proximo_estado = OCIOSO;
      default: w_proximo_estado = OCIOSO;
    endcase
  end

  // resultado is captured on the edge into FIM so it is already valid alongside done
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      r_gnt         <= '0;
      r_ultimo      <= 1'b1;
      r_decrescente <= 1'b0;
      r_passo3      <= 1'b0;
      r_satura      <= 1'b0;
      r_inicio      <= '0;
      r_passos      <= '0;
      r_restante    <= '0;
      r_contagem    <= '0;
      r_resultado   <= '0;
    end else begin
      case (r_estado)
        OCIOSO: begin
          if (|req) begin
            r_gnt         <= w_gnt_novo;
            r_decrescente <= cmd_decrescente[w_idx];
            r_passo3      <= cmd_passo3[w_idx];
            r_satura      <= cmd_satura[w_idx];
            r_inicio      <= w_idx ? cmd_inicio[2*NC-1:NC] : cmd_inicio[NC-1:0];
            r_passos      <= w_idx ? cmd_passos[2*NP-1:NP] : cmd_passos[NP-1:0];
          end
        end
        CARREGA: begin
          r_contagem <= r_inicio;
          r_restante <= r_passos;
          if (r_passos == '0) begin
            r_resultado <= r_inicio;
          end
        end
        CONTA: begin
          if (!congela) begin
            r_contagem <= w_passo_valor;
            r_restante <= r_restante - NP'(1);
            if (r_restante == NP'(1)) begin
              r_resultado <= w_passo_valor;
            end
          end
        end
        FIM: begin
          r_gnt    <= '0;
          r_ultimo <= r_gnt[1];
        end
        default: r_gnt <= '0;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign done      = (r_estado == FIM) ? r_gnt : 2'b00;
  assign ocupado   = (r_estado != OCIOSO);
  assign contagem  = r_contagem;
  assign resultado = r_resultado;

endmodule

// File: tb/tb_contador_arbitro.sv
// Directed bench for contador_arbitro: a vector table of single runs plus
// hand-written sequences for arbitration, pause, zero-length runs and reset.
module tb_contador_arbitro;

  logic       clk_2 = 1'b0;
  logic       reset_n;
  logic [1:0] req;
  logic [1:0] cmd_decrescente;
  logic [1:0] cmd_passo3;
  logic [1:0] cmd_satura;
  logic [7:0] cmd_inicio;
  logic [7:0] cmd_passos;
  logic       congela;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       ocupado;
  logic [3:0] contagem;
  logic [3:0] resultado;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_seq [8];

  typedef struct {
    logic [1:0] req;
    logic       dec;
    logic       p3;
    logic       sat;
    logic [3:0] ini;
    logic [3:0] passos;
    int         exp_res;
    int         exp_lat;
  } vec_t;

  vec_t vecs [10];

  contador_arbitro #(
    .NBITS_CONTAGEM(4),
    .NBITS_PASSOS  (4)
  ) dut (
    .clk_2           (clk_2),
    .reset_n         (reset_n),
    .req             (req),
    .cmd_decrescente (cmd_decrescente),
    .cmd_passo3      (cmd_passo3),
    .cmd_satura      (cmd_satura),
    .cmd_inicio      (cmd_inicio),
    .cmd_passos      (cmd_passos),
    .congela         (congela),
    .gnt             (gnt),
    .done            (done),
    .ocupado         (ocupado),
    .contagem        (contagem),
    .resultado       (resultado)
  );

  always #5 clk_2 = ~clk_2;

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic check(input string nome, input int atual, input int esperado);
    n_checks++;
    if (atual != esperado) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nome, atual, esperado);
    end
  endtask

  task automatic set_cmd(input int i, input logic dec, input logic p3, input logic sat,
                         input logic [3:0] ini, input logic [3:0] ps);
    cmd_decrescente[i] = dec;
    cmd_passo3[i]      = p3;
    cmd_satura[i]      = sat;
    cmd_inicio[i*4 +: 4] = ini;
    cmd_passos[i*4 +: 4] = ps;
  endtask

  task automatic run_vec(input int n_vec, input vec_t v);
    int  idx;
    int  n;
    bit  got;
    idx = v.req[1] ? 1 : 0;
    set_cmd(idx, v.dec, v.p3, v.sat, v.ini, v.passos);
    set_cmd(1 - idx, ~v.dec, ~v.p3, ~v.sat, 4'd5, 4'd1);
    req = v.req;
    tick();
    check($sformatf("vec%0d gnt", n_vec), int'(gnt), int'(v.req));
    check($sformatf("vec%0d ocupado", n_vec), int'(ocupado), 1);
    // changing commands mid-run must not disturb the latched ones
    req = 2'b00;
    set_cmd(idx, ~v.dec, ~v.p3, ~v.sat, v.ini + 4'd3, v.passos + 4'd1);
    n   = 1;
    got = 1'b0;
    while (n < 40 && !got) begin
      tick();
      n++;
      if (done != 2'b00) got = 1'b1;
    end
    check($sformatf("vec%0d done_seen", n_vec), int'(got), 1);
    check($sformatf("vec%0d done", n_vec), int'(done), int'(v.req));
    check($sformatf("vec%0d latency", n_vec), n, v.exp_lat);
    check($sformatf("vec%0d resultado", n_vec), int'(resultado), v.exp_res);
    check($sformatf("vec%0d contagem", n_vec), int'(contagem), v.exp_res);
    tick();
    check($sformatf("vec%0d done_pulse", n_vec), int'(done), 0);
    check($sformatf("vec%0d gnt_idle", n_vec), int'(gnt), 0);
    check($sformatf("vec%0d ocupado_idle", n_vec), int'(ocupado), 0);
    check($sformatf("vec%0d resultado_held", n_vec), int'(resultado), v.exp_res);
  endtask

  task automatic run_seq(input string nome, input logic [1:0] r, input logic dec, input logic p3,
                         input logic sat, input logic [3:0] ini, input logic [3:0] ps,
                         input int len, input int exp_res);
    int idx;
    idx = r[1] ? 1 : 0;
    set_cmd(idx, dec, p3, sat, ini, ps);
    req = r;
    tick();
    check({nome, " gnt"}, int'(gnt), int'(r));
    req = 2'b00;
    for (int k = 0; k < len; k++) begin
      tick();
      check($sformatf("%s seq%0d", nome, k), int'(contagem), exp_seq[k]);
    end
    check({nome, " done"}, int'(done), int'(r));
    check({nome, " resultado"}, int'(resultado), exp_res);
    tick();
    check({nome, " done_pulse"}, int'(done), 0);
  endtask

  initial begin
    int n;
    int exp_g [3];

    reset_n         = 1'b0;
    req             = 2'b00;
    cmd_decrescente = 2'b00;
    cmd_passo3      = 2'b00;
    cmd_satura      = 2'b00;
    cmd_inicio      = 8'h00;
    cmd_passos      = 8'h00;
    congela         = 1'b0;

    vecs[0] = '{2'b01, 1'b0, 1'b0, 1'b0, 4'd2,  4'd4,  6,  6};
    vecs[1] = '{2'b10, 1'b0, 1'b1, 1'b0, 4'd14, 4'd2,  4,  4};
    vecs[2] = '{2'b10, 1'b0, 1'b1, 1'b1, 4'd14, 4'd2,  15, 4};
    vecs[3] = '{2'b01, 1'b1, 1'b0, 1'b0, 4'd9,  4'd3,  6,  5};
    vecs[4] = '{2'b10, 1'b0, 1'b0, 1'b0, 4'd7,  4'd0,  7,  2};
    vecs[5] = '{2'b01, 1'b1, 1'b1, 1'b1, 4'd4,  4'd2,  0,  4};
    vecs[6] = '{2'b10, 1'b1, 1'b1, 1'b0, 4'd1,  4'd1,  14, 3};
    vecs[7] = '{2'b01, 1'b0, 1'b0, 1'b1, 4'd15, 4'd3,  15, 5};
    vecs[8] = '{2'b10, 1'b0, 1'b0, 1'b0, 4'd15, 4'd1,  0,  3};
    vecs[9] = '{2'b01, 1'b0, 1'b0, 1'b0, 4'd0,  4'd15, 15, 17};

    #12;
    check("rst gnt", int'(gnt), 0);
    check("rst done", int'(done), 0);
    check("rst ocupado", int'(ocupado), 0);
    check("rst contagem", int'(contagem), 0);
    check("rst resultado", int'(resultado), 0);
    reset_n = 1'b1;

    // both requesting continuously: 0 first after reset, then alternate
    set_cmd(0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1);
    set_cmd(1, 1'b0, 1'b0, 1'b0, 4'd8, 4'd1);
    req = 2'b11;
    exp_g = '{1, 2, 1};
    for (int r = 0; r < 3; r++) begin
      n = 0;
      do begin tick(); n++; end while (gnt == 2'b00 && n < 10);
      check($sformatf("rr%0d gnt", r), int'(gnt), exp_g[r]);
      n = 0;
      do begin tick(); n++; end while (done == 2'b00 && n < 10);
      check($sformatf("rr%0d done", r), int'(done), exp_g[r]);
    end
    req = 2'b00;
    tick();
    tick();
    check("rr idle", int'(ocupado), 0);

    exp_seq = '{2, 3, 4, 5, 6, 0, 0, 0};
    run_seq("up1", 2'b01, 1'b0, 1'b0, 1'b0, 4'd2, 4'd4, 5, 6);
    exp_seq = '{14, 1, 4, 0, 0, 0, 0, 0};
    run_seq("up3wrap", 2'b10, 1'b0, 1'b1, 1'b0, 4'd14, 4'd2, 3, 4);
    exp_seq = '{14, 15, 15, 0, 0, 0, 0, 0};
    run_seq("up3sat", 2'b10, 1'b0, 1'b1, 1'b1, 4'd14, 4'd2, 3, 15);

    for (int i = 0; i < 10; i++) begin
      run_vec(i, vecs[i]);
    end

    // pause for two cycles in CONTA stretches the run by exactly two cycles
    set_cmd(0, 1'b1, 1'b0, 1'b0, 4'd9, 4'd3);
    req = 2'b01;
    tick();
    n = 1;
    req = 2'b00;
    tick(); n++;
    check("frz load", int'(contagem), 9);
    tick(); n++;
    check("frz step1", int'(contagem), 8);
    congela = 1'b1;
    tick(); n++;
    tick(); n++;
    check("frz hold", int'(contagem), 8);
    check("frz no_done", int'(done), 0);
    congela = 1'b0;
    while (done == 2'b00 && n < 30) begin
      tick();
      n++;
    end
    check("frz latency", n, 7);
    check("frz done", int'(done), 1);
    check("frz resultado", int'(resultado), 6);
    tick();

    // zero-step run; congela must not matter outside CONTA
    congela = 1'b1;
    set_cmd(1, 1'b0, 1'b0, 1'b0, 4'd7, 4'd0);
    req = 2'b10;
    tick();
    req = 2'b00;
    tick();
    check("zero done", int'(done), 2);
    check("zero resultado", int'(resultado), 7);
    check("zero contagem", int'(contagem), 7);
    congela = 1'b0;
    tick();
    check("zero idle", int'(ocupado), 0);

    // asynchronous reset mid-run
    set_cmd(1, 1'b0, 1'b0, 1'b0, 4'd3, 4'd5);
    req = 2'b10;
    tick();
    req = 2'b00;
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("arst gnt", int'(gnt), 0);
    check("arst done", int'(done), 0);
    check("arst ocupado", int'(ocupado), 0);
    check("arst contagem", int'(contagem), 0);
    check("arst resultado", int'(resultado), 0);
    tick();
    check("arst hold_done", int'(done), 0);
    reset_n = 1'b1;
    set_cmd(0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1);
    set_cmd(1, 1'b0, 1'b0, 1'b0, 4'd2, 4'd1);
    req = 2'b11;
    tick();
    check("arst regrant", int'(gnt), 1);
    req = 2'b00;
    n = 0;
    do begin tick(); n++; end while (done == 2'b00 && n < 10);
    check("arst post_done", int'(done), 1);
    check("arst post_res", int'(resultado), 2);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
